// File: rtl/mem_responder_pkg.sv
// Shared types for the memory responder: FSM state encoding and port grant codes.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    MEMRESP_IDLE   = 2'd0,
    MEMRESP_WAIT   = 2'd1,
    MEMRESP_ACCESS = 2'd2,
    MEMRESP_RESP   = 2'd3
  } state_e;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_e;

  // Wide enough for the largest legal LATENCY-1 (14).
  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_responder.sv
// Arbitrates instruction-fetch and data requests onto one synchronous RAM,
// with a programmable wait before each access and a one-cycle ready pulse back.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_mem_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [DATA_WIDTH-1:0] i_data,
  output logic                  i_ready,
  input  logic                  d_mem_read,
  input  logic                  d_mem_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ready,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_e                state_q, state_d;
  grant_e                grant_q, grant_d;
  logic                  op_we_q, op_we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_we_q, mem_we_d;
  logic                  i_ready_q, i_ready_d;
  logic                  d_ready_q, d_ready_d;
  logic [DATA_WIDTH-1:0] i_data_q, i_data_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    op_we_d   = op_we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    mem_en_d  = 1'b0;
    mem_we_d  = 1'b0;
    i_ready_d = 1'b0;
    d_ready_d = 1'b0;

    // RAM read data arrives during RESP, so the data outputs pass it straight
    // through in that cycle and hold it afterwards.
    i_data_d  = (state_q == MEMRESP_RESP && grant_q == GRANT_I) ? mem_rdata : i_data_q;
    d_rdata_d = (state_q == MEMRESP_RESP && grant_q == GRANT_D && !op_we_q) ? mem_rdata
                                                                            : d_rdata_q;

    case (state_q)
      MEMRESP_IDLE: begin
        // Data port wins: the older instruction sitting in MEM must not stall.
        if (d_mem_read || d_mem_write) begin
          grant_d = GRANT_D;
          op_we_d = d_mem_write;
          addr_d  = d_address;
          wdata_d = d_wdata;
          cnt_d   = CNT_LOAD;
          state_d = MEMRESP_WAIT;
        end else if (i_mem_read) begin
          grant_d = GRANT_I;
          op_we_d = 1'b0;
          addr_d  = i_address;
          wdata_d = d_wdata;
          cnt_d   = CNT_LOAD;
          state_d = MEMRESP_WAIT;
        end
      end
      MEMRESP_WAIT: begin
        if (cnt_q == '0) begin
          state_d  = MEMRESP_ACCESS;
          mem_en_d = 1'b1;
          mem_we_d = op_we_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      MEMRESP_ACCESS: begin
        state_d   = MEMRESP_RESP;
        i_ready_d = (grant_q == GRANT_I);
        d_ready_d = (grant_q == GRANT_D);
      end
      default: begin
        state_d = MEMRESP_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= MEMRESP_IDLE;
      grant_q   <= GRANT_I;
      op_we_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      mem_en_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      i_data_q  <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      op_we_q   <= op_we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      mem_en_q  <= mem_en_d;
      mem_we_q  <= mem_we_d;
      i_ready_q <= i_ready_d;
      d_ready_q <= d_ready_d;
      i_data_q  <= i_data_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign i_ready   = i_ready_q;
  assign d_ready   = d_ready_q;
  assign i_data    = i_data_d;
  assign d_rdata   = d_rdata_d;

endmodule
